// File: rtl/ice_bus_arbiter.sv
// Slave-bus arbiter for the ICE bus controller: one-hot grant of the shared sl_* bus,
// fixed-priority or round-robin policy, downstream-ready gate and hold-timeout watchdog.
module ice_bus_arbiter #(
  parameter int NUM_DEV   = 7,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT_W = 16,
  parameter int RR_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_DEV-1:0]   sl_arb_request,
  input  logic                 bus_ready,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [NUM_DEV-1:0]   sl_arb_grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout_pulse,
  output logic [7:0]           timeout_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_DEV-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 pulse_q, pulse_d;
  logic [7:0]           tcnt_q, tcnt_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_DEV-1:0]   lockout_q, lockout_d;
  logic [TIMEOUT_W-1:0] hold_q, hold_d;

  logic [NUM_DEV-1:0]   elig;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     search_base;

  // First set bit of elig at or above base, wrapping past NUM_DEV-1 to 0.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_DEV-1:0] req,
                                            input logic [IDX_W-1:0]   base);
    logic           found;
    int             c;
    logic [IDX_W-1:0] ci;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      c = int'(base) + k;
      if (c >= NUM_DEV) c = c - NUM_DEV;
      ci = IDX_W'(c);
      if (!found && req[ci]) begin
        pick  = ci;
        found = 1'b1;
      end
    end
  endfunction

  assign elig        = sl_arb_request & ~lockout_q;
  assign search_base = (RR_MODE != 0) ? rr_ptr_q : '0;
  assign winner      = pick(elig, search_base);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    pulse_d   = 1'b0;
    tcnt_d    = tcnt_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    // A lockout only survives while the offender keeps requesting.
    lockout_d = lockout_q & sl_arb_request;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (bus_ready && (|elig)) begin
          grant_d  = {{(NUM_DEV-1){1'b0}}, 1'b1} << winner;
          valid_d  = 1'b1;
          idx_d    = winner;
          rr_ptr_d = (winner == IDX_W'(NUM_DEV-1)) ? '0 : winner + 1'b1;
          hold_d   = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (!sl_arb_request[idx_q]) begin
          grant_d = '0;
          valid_d = 1'b0;
          state_d = S_RELEASE;
        end else if ((timeout_limit != '0) &&
                     (hold_q == timeout_limit - TIMEOUT_W'(1))) begin
          grant_d          = '0;
          valid_d          = 1'b0;
          lockout_d[idx_q] = 1'b1;
          pulse_d          = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d          = S_RELEASE;
        end
      end
      S_RELEASE: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      pulse_q   <= 1'b0;
      tcnt_q    <= '0;
      rr_ptr_q  <= '0;
      lockout_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      pulse_q   <= pulse_d;
      tcnt_q    <= tcnt_d;
      rr_ptr_q  <= rr_ptr_d;
      lockout_q <= lockout_d;
      hold_q    <= hold_d;
    end
  end

  assign sl_arb_grant  = grant_q;
  assign grant_valid   = valid_q;
  assign grant_idx     = idx_q;
  assign timeout_pulse = pulse_q;
  assign timeout_count = tcnt_q;

endmodule
